// File: rtl/alu_divider.sv
// Sequential 8-bit unsigned restoring divider with a start/busy/done handshake.
// One quotient bit is retired per clock; results appear only on completion.
module alu_divider (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    input  logic       in_start,
    output logic [7:0] out_quotient,
    output logic [7:0] out_remainder,
    output logic       out_busy,
    output logic       out_done,
    output logic       out_div_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] count_q, count_d;
    logic [7:0] rem_q, rem_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] divisor_q, divisor_d;
    logic [7:0] quotient_q, quotient_d;
    logic [7:0] remainder_q, remainder_d;
    logic       div_zero_q, div_zero_d;

    // The partial remainder always stays below the divisor, so 8 stored bits
    // suffice; the shifted trial operand is the full 9-bit value.
    logic [8:0] shifted;
    logic [8:0] trial;
    logic [7:0] iter_rem;
    logic [7:0] iter_quo;

    always_comb begin
        shifted = {rem_q, shift_q[7]};
        trial   = shifted - {1'b0, divisor_q};
        if (!trial[8]) begin
            iter_rem = trial[7:0];
            iter_quo = {shift_q[6:0], 1'b1};
        end else begin
            iter_rem = shifted[7:0];
            iter_quo = {shift_q[6:0], 1'b0};
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        shift_d     = shift_q;
        divisor_d   = divisor_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (in_start) begin
                    if (in_b == 8'd0) begin
                        state_d     = DONE;
                        quotient_d  = 8'hFF;
                        remainder_d = in_a;
                        div_zero_d  = 1'b1;
                    end else begin
                        state_d    = RUN;
                        divisor_d  = in_b;
                        rem_d      = 8'd0;
                        shift_d    = in_a;
                        count_d    = 4'd0;
                        div_zero_d = 1'b0;
                    end
                end
            end
            RUN: begin
                rem_d   = iter_rem;
                shift_d = iter_quo;
                count_d = count_q + 4'd1;
                if (count_q == 4'd7) begin
                    state_d     = DONE;
                    quotient_d  = iter_quo;
                    remainder_d = iter_rem;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= 4'd0;
            rem_q       <= 8'd0;
            shift_q     <= 8'd0;
            divisor_q   <= 8'd0;
            quotient_q  <= 8'd0;
            remainder_q <= 8'd0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            shift_q     <= shift_d;
            divisor_q   <= divisor_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign out_quotient  = quotient_q;
    assign out_remainder = remainder_q;
    assign out_busy      = (state_q == RUN);
    assign out_done      = (state_q == DONE);
    assign out_div_zero  = div_zero_q;

endmodule

// File: tb/tb_alu_divider.sv
// Scoreboard bench for alu_divider: stimulus pushes expected results, a
// negedge monitor pops and checks them whenever out_done is seen.
module tb_alu_divider;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_start;
    logic [7:0] out_quotient;
    logic [7:0] out_remainder;
    logic       out_busy;
    logic       out_done;
    logic       out_div_zero;

    alu_divider dut (
        .clk          (clk),
        .reset        (reset),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_start     (in_start),
        .out_quotient (out_quotient),
        .out_remainder(out_remainder),
        .out_busy     (out_busy),
        .out_done     (out_done),
        .out_div_zero (out_div_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         due;
        int         busy;
        logic [7:0] a;
        logic [7:0] b;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   busy_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compares every presented result against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            busy_cnt = 0;
        end else begin
            chk("busy_done_exclusive", {31'd0, out_busy & out_done}, 32'd0);
            if (out_busy) busy_cnt++;
            if (out_done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done with q=%0d r=%0d, expected no result", out_quotient, out_remainder);
                end else begin
                    e = exp_q.pop_front();
                    chk("quotient",  {24'd0, out_quotient},  {24'd0, e.q});
                    chk("remainder", {24'd0, out_remainder}, {24'd0, e.r});
                    chk("div_zero",  {31'd0, out_div_zero},  {31'd0, e.dz});
                    chk("latency",   cyc,      e.due);
                    chk("busy_cycles", busy_cnt, e.busy);
                    $display("txn %0d/%0d -> q=%0d r=%0d dz=%0d (cycle %0d, busy %0d)",
                             e.a, e.b, out_quotient, out_remainder, out_div_zero, cyc, busy_cnt);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic push_exp(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] q, input logic [7:0] r, input logic dz);
        exp_t e;
        e.a    = a;
        e.b    = b;
        e.q    = q;
        e.r    = r;
        e.dz   = dz;
        e.due  = dz ? cyc : cyc + 8;
        e.busy = dz ? 0 : 8;
        exp_q.push_back(e);
    endtask

    // Presents a one-cycle start; returns 1ns after the accepting edge.
    task automatic start_div(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] q, input logic [7:0] r, input logic dz);
        @(negedge clk);
        in_a     = a;
        in_b     = b;
        in_start = 1'b1;
        @(posedge clk);
        #1;
        in_start = 1'b0;
        push_exp(a, b, q, r, dz);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_quotient"},  {24'd0, out_quotient},  32'd0);
        chk({tag, "_remainder"}, {24'd0, out_remainder}, 32'd0);
        chk({tag, "_busy"},      {31'd0, out_busy},      32'd0);
        chk({tag, "_done"},      {31'd0, out_done},      32'd0);
        chk({tag, "_div_zero"},  {31'd0, out_div_zero},  32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected end within 100000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        in_start = 1'b0;
        in_a     = 8'd0;
        in_b     = 8'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");

        // Basic and boundary operands
        start_div(8'd200, 8'd7,   8'd28,  8'd4, 1'b0); drain();
        start_div(8'd255, 8'd1,   8'd255, 8'd0, 1'b0); drain();
        start_div(8'd5,   8'd9,   8'd0,   8'd5, 1'b0); drain();
        start_div(8'd255, 8'd255, 8'd1,   8'd0, 1'b0); drain();
        start_div(8'd0,   8'd3,   8'd0,   8'd0, 1'b0); drain();

        // Divide by zero, flag holds, next valid start clears it
        start_div(8'd100, 8'd0, 8'hFF, 8'd100, 1'b1); drain();
        chk("dz_hold", {31'd0, out_div_zero}, 32'd1);
        start_div(8'd7, 8'd2, 8'd3, 8'd1, 1'b0);
        @(negedge clk);
        chk("dz_cleared", {31'd0, out_div_zero}, 32'd0);
        drain();

        // Start during RUN ignored; start held into DONE accepted back-to-back
        start_div(8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        in_a = 8'd9; in_b = 8'd3; in_start = 1'b1;
        @(posedge clk);
        #1 in_start = 1'b0; in_a = 8'd0; in_b = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        in_a = 8'd9; in_b = 8'd3; in_start = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 in_start = 1'b0;
        push_exp(8'd9, 8'd3, 8'd3, 8'd0, 1'b0);
        drain();

        // Reset mid-RUN, with a simultaneous start that must be ignored
        start_div(8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1; in_start = 1'b1; in_a = 8'd50; in_b = 8'd6;
        @(posedge clk);
        #1 exp_q.delete();
        @(negedge clk);
        chk_all_zero("midrun_reset");
        @(posedge clk);
        #1 reset = 1'b0; in_start = 1'b0;
        @(negedge clk);
        chk("post_reset_busy", {31'd0, out_busy}, 32'd0);
        chk("post_reset_done", {31'd0, out_done}, 32'd0);
        start_div(8'd50, 8'd6, 8'd8, 8'd2, 1'b0); drain();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
